// File: rtl/dvi_video_timing_if.sv
// DVI video timing bundle: run controls into the generator, sync/DE/pixel data out.
// master = timing generator, slave = consumer of the video stream.
interface dvi_video_timing_if;
    logic        iEn;
    logic [1:0]  iMode;
    logic        oDviHsync;
    logic        oDviVsync;
    logic        oDviDe;
    logic [11:0] oDviDataRise;
    logic [11:0] oDviDataFall;
    logic        oFrameStart;

    modport master (
        input  iEn, iMode,
        output oDviHsync, oDviVsync, oDviDe, oDviDataRise, oDviDataFall, oFrameStart
    );

    modport slave (
        output iEn, iMode,
        input  oDviHsync, oDviVsync, oDviDe, oDviDataRise, oDviDataFall, oFrameStart
    );
endinterface

// File: rtl/dvi_video_timing.sv
// Video timing and test-pattern generator for the DVI path; outputs are registered one cycle after the counters.
// Optional DVI_TIMING_SCROLL_EN: pattern scrolls left one pixel per frame.
module dvi_video_timing #(
    parameter int          H_ACTIVE   = 640,
    parameter int          H_FP       = 16,
    parameter int          H_SYNC     = 96,
    parameter int          H_BP       = 48,
    parameter int          V_ACTIVE   = 480,
    parameter int          V_FP       = 10,
    parameter int          V_SYNC     = 2,
    parameter int          V_BP       = 33,
    parameter logic        HS_POL     = 1'b0,
    parameter logic        VS_POL     = 1'b0,
    parameter int          CHECK_LOG2 = 4,
    parameter logic [23:0] SOLID_RGB  = 24'h0000FF
) (
    input logic iSysClk,
    input logic iSysRst,
    dvi_video_timing_if.master dvi
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int BAR_W   = H_ACTIVE >> 3;
    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

    logic [HW-1:0] hCnt;
    logic [VW-1:0] vCnt;
    logic [1:0]    modeReg;
    logic [1:0]    modeEff;
    logic          atOrigin, hEnd, vEnd;
    logic          active, hsAct, vsAct;
    logic [31:0]   xPix, yPix, xs;
    logic [2:0]    barIdx;
    logic [23:0]   rgb;
`ifdef DVI_TIMING_SCROLL_EN
    logic [HW-1:0] scrollOff;
`endif

    always_comb begin
        atOrigin = (hCnt == '0) && (vCnt == '0);
        hEnd     = (hCnt == H_LAST);
        vEnd     = (vCnt == V_LAST);
        // The origin pixel already belongs to the new frame, so it sees the freshly sampled mode.
        modeEff  = atOrigin ? dvi.iMode : modeReg;
        xPix     = 32'(hCnt);
        yPix     = 32'(vCnt);
`ifdef DVI_TIMING_SCROLL_EN
        xs = xPix + 32'(scrollOff);
        if (xs >= 32'(H_ACTIVE)) xs = xs - 32'(H_ACTIVE);
`else
        xs = xPix;
`endif
        active = (xPix < 32'(H_ACTIVE)) && (yPix < 32'(V_ACTIVE));
        hsAct  = (xPix >= 32'(H_ACTIVE + H_FP)) && (xPix < 32'(H_ACTIVE + H_FP + H_SYNC));
        vsAct  = (yPix >= 32'(V_ACTIVE + V_FP)) && (yPix < 32'(V_ACTIVE + V_FP + V_SYNC));

        barIdx = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (xs >= 32'(k * BAR_W)) barIdx = barIdx + 3'd1;
        end

        rgb = 24'h000000;
        case (modeEff)
            2'd0: begin
                case (barIdx)
                    3'd0:    rgb = 24'hFFFFFF;
                    3'd1:    rgb = 24'hFFFF00;
                    3'd2:    rgb = 24'h00FFFF;
                    3'd3:    rgb = 24'h00FF00;
                    3'd4:    rgb = 24'hFF00FF;
                    3'd5:    rgb = 24'hFF0000;
                    3'd6:    rgb = 24'h0000FF;
                    default: rgb = 24'h000000;
                endcase
            end
            2'd1:    rgb = (xs[CHECK_LOG2] ^ yPix[CHECK_LOG2]) ? 24'hFFFFFF : 24'h000000;
            2'd2:    rgb = {3{xs[7:0]}};
            default: rgb = SOLID_RGB;
        endcase
        if (!active) rgb = 24'h000000;
    end

    always_ff @(posedge iSysClk or posedge iSysRst) begin
        if (iSysRst) begin
            hCnt             <= '0;
            vCnt             <= '0;
            modeReg          <= 2'd0;
            dvi.oDviHsync    <= ~HS_POL;
            dvi.oDviVsync    <= ~VS_POL;
            dvi.oDviDe       <= 1'b0;
            dvi.oDviDataRise <= 12'h000;
            dvi.oDviDataFall <= 12'h000;
            dvi.oFrameStart  <= 1'b0;
`ifdef DVI_TIMING_SCROLL_EN
            scrollOff        <= '0;
`endif
        end else if (!dvi.iEn) begin
            hCnt             <= '0;
            vCnt             <= '0;
            modeReg          <= 2'd0;
            dvi.oDviHsync    <= ~HS_POL;
            dvi.oDviVsync    <= ~VS_POL;
            dvi.oDviDe       <= 1'b0;
            dvi.oDviDataRise <= 12'h000;
            dvi.oDviDataFall <= 12'h000;
            dvi.oFrameStart  <= 1'b0;
`ifdef DVI_TIMING_SCROLL_EN
            scrollOff        <= '0;
`endif
        end else begin
            if (hEnd) begin
                hCnt <= '0;
                vCnt <= vEnd ? '0 : vCnt + 1'b1;
            end else begin
                hCnt <= hCnt + 1'b1;
            end
            if (atOrigin) modeReg <= dvi.iMode;
`ifdef DVI_TIMING_SCROLL_EN
            // Advance on the last pixel so the whole next frame, origin included, uses the new offset.
            if (hEnd && vEnd)
                scrollOff <= (scrollOff == HW'(H_ACTIVE - 1)) ? '0 : scrollOff + 1'b1;
`endif
            dvi.oDviHsync    <= hsAct ? HS_POL : ~HS_POL;
            dvi.oDviVsync    <= vsAct ? VS_POL : ~VS_POL;
            dvi.oDviDe       <= active;
            dvi.oDviDataRise <= rgb[11:0];
            dvi.oDviDataFall <= rgb[23:12];
            dvi.oFrameStart  <= atOrigin;
        end
    end
endmodule

// File: tb/tb_dvi_video_timing.sv
// Self-checking bench for dvi_video_timing: pixel vector table, hand-written corner sequences,
// and randomized run checked against a frame-arithmetic reference model.
module tb_dvi_video_timing;
    localparam int HA = 16, HF = 2, HS = 3, HB = 3;
    localparam int VA = 8,  VF = 1, VS = 2, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;
    localparam logic HSP = 1'b1;
    localparam logic VSP = 1'b0;
    localparam int CL = 1;
    localparam logic [23:0] SOLID = 24'h0000FF;

    logic clk = 1'b0;
    logic rst = 1'b1;

    dvi_video_timing_if dvi();

    dvi_video_timing #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HS_POL(HSP), .VS_POL(VSP), .CHECK_LOG2(CL), .SOLID_RGB(SOLID)
    ) dut (
        .iSysClk(clk),
        .iSysRst(rst),
        .dvi(dvi.master)
    );

    always #5 clk = ~clk;

    int nCmp = 0;
    int nBad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeoutFail(input string name);
        nCmp++;
        nBad++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    function automatic logic [27:0] outVec();
        return {dvi.oDviHsync, dvi.oDviVsync, dvi.oDviDe, dvi.oFrameStart,
                dvi.oDviDataRise, dvi.oDviDataFall};
    endfunction

    localparam logic [27:0] IDLE_VEC = {~HSP, ~VSP, 1'b0, 1'b0, 24'h000000};

    // Reference model: pixel position follows from the number of enabled cycles since start.
    function automatic logic [23:0] pixelRgb(input int x, input int y, input logic [1:0] m, input int off);
        int xs;
        if (x >= HA || y >= VA) return 24'h0;
        xs = (x + off) % HA;
        case (m)
            2'd0: begin
                case (xs / (HA / 8))
                    0: return 24'hFFFFFF;
                    1: return 24'hFFFF00;
                    2: return 24'h00FFFF;
                    3: return 24'h00FF00;
                    4: return 24'hFF00FF;
                    5: return 24'hFF0000;
                    6: return 24'h0000FF;
                    default: return 24'h000000;
                endcase
            end
            2'd1: return ((((xs >> CL) ^ (y >> CL)) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
            2'd2: return {3{8'(xs)}};
            default: return SOLID;
        endcase
    endfunction

    logic [27:0] mVec = IDLE_VEC;
    int tCnt = 0;
    logic [1:0] fMode = 2'd0;
    int mp, mx, my, moff;
    logic [23:0] mRgb;

    always @(posedge clk or posedge rst) begin
        if (rst || !dvi.iEn) begin
            mVec = IDLE_VEC;
            tCnt = 0;
        end else begin
            mp = tCnt % FRAME;
            mx = mp % HT;
            my = mp / HT;
            if (mp == 0) fMode = dvi.iMode;
            moff = 0;
`ifdef DVI_TIMING_SCROLL_EN
            moff = (tCnt / FRAME) % HA;
`endif
            mRgb = pixelRgb(mx, my, fMode, moff);
            mVec = {((mx >= HA + HF && mx < HA + HF + HS) ? HSP : ~HSP),
                    ((my >= VA + VF && my < VA + VF + VS) ? VSP : ~VSP),
                    (mx < HA && my < VA), (mp == 0),
                    mRgb[11:0], mRgb[23:12]};
            tCnt++;
        end
    end

    always @(negedge clk) begin
        if (!rst) chk("model_stream", 32'(outVec()), 32'(mVec));
    end

    typedef struct {
        logic [1:0]  mode;
        int          x;
        int          y;
        logic        de;
        logic [11:0] rise;
        logic [11:0] fall;
    } vec_t;

    vec_t tbl[10];

    task automatic restart(input logic [1:0] mode);
        @(negedge clk);
        dvi.iEn = 1'b0;
        @(negedge clk);
        dvi.iMode = mode;
        dvi.iEn = 1'b1;
    endtask

    task automatic waitFs(input string name);
        bit ok;
        ok = 0;
        for (int i = 0; i < FRAME + 20; i++) begin
            @(negedge clk);
            if (dvi.oFrameStart === 1'b1) begin
                ok = 1;
                break;
            end
        end
        if (!ok) timeoutFail(name);
    endtask

    int cntDe, cntHs, cntVs, gap;

    initial begin
        tbl[0] = '{2'd0, 0,  0, 1'b1, 12'hFFF, 12'hFFF};
        tbl[1] = '{2'd0, 12, 0, 1'b1, 12'h0FF, 12'h000};
        tbl[2] = '{2'd0, 3,  1, 1'b1, 12'hF00, 12'hFFF};
        tbl[3] = '{2'd0, 14, 7, 1'b1, 12'h000, 12'h000};
        tbl[4] = '{2'd1, 2,  0, 1'b1, 12'hFFF, 12'hFFF};
        tbl[5] = '{2'd1, 0,  0, 1'b1, 12'h000, 12'h000};
        tbl[6] = '{2'd1, 2,  2, 1'b1, 12'h000, 12'h000};
        tbl[7] = '{2'd2, 5,  3, 1'b1, 12'h505, 12'h050};
        tbl[8] = '{2'd3, 9,  4, 1'b1, 12'h0FF, 12'h000};
        tbl[9] = '{2'd0, 16, 0, 1'b0, 12'h000, 12'h000};

        dvi.iEn = 1'b0;
        dvi.iMode = 2'd0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_idle", 32'(outVec()), 32'(IDLE_VEC));
        rst = 1'b0;

        // Pixel vectors from a fresh frame
        for (int i = 0; i < 10; i++) begin
            restart(tbl[i].mode);
            repeat (tbl[i].y * HT + tbl[i].x + 1) @(negedge clk);
            chk($sformatf("vec%0d_de", i), 32'(dvi.oDviDe), 32'(tbl[i].de));
            chk($sformatf("vec%0d_rise", i), 32'(dvi.oDviDataRise), 32'(tbl[i].rise));
            chk($sformatf("vec%0d_fall", i), 32'(dvi.oDviDataFall), 32'(tbl[i].fall));
        end

        // Frame-level timing counts
        restart(2'd0);
        waitFs("fs_first");
        cntDe = 0; cntHs = 0; cntVs = 0; gap = 0;
        for (int i = 0; i < FRAME + 20; i++) begin
            if (dvi.oDviDe === 1'b1) cntDe++;
            if (dvi.oDviHsync === HSP) cntHs++;
            if (dvi.oDviVsync === VSP) cntVs++;
            @(negedge clk);
            gap++;
            if (dvi.oFrameStart === 1'b1) break;
        end
        chk("fs_period", 32'(gap), 32'(FRAME));
        chk("de_per_frame", 32'(cntDe), 32'(HA * VA));
        chk("hs_per_frame", 32'(cntHs), 32'(HS * VT));
        chk("vs_per_frame", 32'(cntVs), 32'(VS * HT));

        // Mode change mid-frame applies from the next frame
        restart(2'd3);
        repeat (5 * HT + 3 + 1) @(negedge clk);
        chk("mode_solid_before", 32'(dvi.oDviDataRise), 32'h0FF);
        dvi.iMode = 2'd1;
        repeat (HT) @(negedge clk);
        chk("mode_solid_hold", 32'(dvi.oDviDataRise), 32'h0FF);
        waitFs("mode_fs");
        chk("mode_check_origin", 32'({dvi.oDviDataRise, dvi.oDviDataFall}), 32'h000000);
        repeat (2) @(negedge clk);
        chk("mode_check_x2", 32'({dvi.oDviDataRise, dvi.oDviDataFall}), 32'hFFFFFF);

        // Enable dropped at (5,3) for 10 cycles
        restart(2'd0);
        repeat (3 * HT + 5) @(negedge clk);
        dvi.iEn = 1'b0;
        @(negedge clk);
        chk("en_drop_idle", 32'(outVec()), 32'(IDLE_VEC));
        repeat (9) @(negedge clk);
        dvi.iEn = 1'b1;
        @(negedge clk);
        chk("en_fs_after", 32'(dvi.oFrameStart), 32'd1);
        chk("en_pixel0", 32'(dvi.oDviDataRise), 32'hFFF);

        // Asynchronous reset between edges while hsync is active
        restart(2'd0);
        repeat (HA + HF + 1 + 1) @(negedge clk);
        chk("hs_active_pre", 32'(dvi.oDviHsync), 32'(HSP));
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_idle", 32'(outVec()), 32'(IDLE_VEC));
        chk("async_rst_hs0", 32'(dvi.oDviHsync), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_fs_after", 32'(dvi.oFrameStart), 32'd1);

`ifdef DVI_TIMING_SCROLL_EN
        restart(2'd2);
        for (int f = 0; f <= HA; f++) begin
            waitFs("scroll_fs");
            chk($sformatf("scroll_f%0d", f), 32'(dvi.oDviDataRise[7:0]), 32'(f % HA));
        end
`endif

        // Randomized modes and enable drops against the model
        restart(2'($urandom_range(0, 3)));
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 63) == 0) dvi.iMode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1499) == 0) begin
                dvi.iEn = 1'b0;
                repeat ($urandom_range(1, 20)) @(negedge clk);
                dvi.iEn = 1'b1;
            end
        end

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end
endmodule
